// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the fetch-stage sequencer: PC width, default start
// address and the four-state FSM encoding.
package pc_fetch_pkg;

  localparam int PC_W = 16;

  localparam logic [PC_W-1:0] DEFAULT_START_ADDR = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_ISSUE  = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/fetch_timeout_counter.sv
// Cycle counter for an outstanding instruction fetch. terminal is high on the
// TIMEOUT_CYCLES-th consecutive enabled cycle since the last clear.
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic clear,
  output logic terminal
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Count enabled cycles, saturating at the terminal value; clear wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign terminal = enable && (count == LAST);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: drives reg_pc, fetches from instruction memory over
// req/ack and hands each instruction to decode over valid/ready.
// Optional fetch timeout is enabled by defining PC_FETCH_TIMEOUT_EN.
//
// Handshakes: imem_req/imem_addr are held stable until imem_ack is sampled
// high (never withdrawn early, except by reset or timeout). instr/instr_valid
// are held stable until instr_ready is sampled high; a transfer happens on
// the cycle where both are high.
module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter logic [PC_W-1:0] START_ADDR     = DEFAULT_START_ADDR,
  parameter int              INSTR_W        = 16,
  parameter int              TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [PC_W-1:0]    pc_value,
  output logic               pc_inc,
  output logic               pc_load,
  output logic [PC_W-1:0]    pc_load_value,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_take,
  input  logic [PC_W-1:0]    branch_target,
  input  logic               halt,
  output logic               halted,
  output logic               fetch_err,
  output fetch_state_e       state_dbg
);

  fetch_state_e        state, state_nxt;
  logic                req_nxt, valid_nxt, halted_nxt, err_nxt;
  logic [PC_W-1:0]     addr_nxt;
  logic [INSTR_W-1:0]  instr_nxt;
  logic                inc_c, load_c;
  logic [PC_W-1:0]     load_val_c;
  logic                timeout_hit;

`ifdef PC_FETCH_TIMEOUT_EN
  logic cnt_clear;
  logic cnt_enable;

  assign cnt_enable = (state == ST_FETCH);
  assign cnt_clear  = (state_nxt == ST_FETCH) && (state != ST_FETCH);

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .reset    (reset),
    .enable   (cnt_enable),
    .clear    (cnt_clear),
    .terminal (timeout_hit)
  );
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; Mealy PC controls are decided here too.
  always_comb begin
    state_nxt  = state;
    req_nxt    = imem_req;
    addr_nxt   = imem_addr;
    instr_nxt  = instr;
    valid_nxt  = instr_valid;
    halted_nxt = halted;
    err_nxt    = fetch_err;
    inc_c      = 1'b0;
    load_c     = 1'b0;
    load_val_c = '0;
    case (state)
      ST_IDLE, ST_HALTED: begin
        if (!halt && start) begin
          load_c     = 1'b1;
          load_val_c = START_ADDR;
          addr_nxt   = START_ADDR;
          req_nxt    = 1'b1;
          halted_nxt = 1'b0;
          state_nxt  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        if (imem_ack) begin
          inc_c   = 1'b1;
          req_nxt = 1'b0;
          if (halt) begin
            halted_nxt = 1'b1;
            state_nxt  = ST_HALTED;
          end else begin
            instr_nxt = imem_rdata;
            valid_nxt = 1'b1;
            state_nxt = ST_ISSUE;
          end
        end else if (timeout_hit) begin
          req_nxt    = 1'b0;
          err_nxt    = 1'b1;
          halted_nxt = 1'b1;
          state_nxt  = ST_HALTED;
        end
      end
      ST_ISSUE: begin
        if (halt) begin
          valid_nxt  = 1'b0;
          halted_nxt = 1'b1;
          state_nxt  = ST_HALTED;
        end else if (instr_ready) begin
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          state_nxt = ST_FETCH;
          // reg_pc was incremented on the ack edge, so pc_value already
          // points at the next sequential instruction.
          if (branch_take) begin
            load_c     = 1'b1;
            load_val_c = branch_target;
            addr_nxt   = branch_target;
          end else begin
            addr_nxt = pc_value;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= ST_IDLE;
      imem_req    <= 1'b0;
      imem_addr   <= '0;
      instr       <= '0;
      instr_valid <= 1'b0;
      halted      <= 1'b0;
      fetch_err   <= 1'b0;
    end else begin
      state       <= state_nxt;
      imem_req    <= req_nxt;
      imem_addr   <= addr_nxt;
      instr       <= instr_nxt;
      instr_valid <= valid_nxt;
      halted      <= halted_nxt;
      fetch_err   <= err_nxt;
    end
  end

  // Mealy PC controls are forced low while reset is asserted.
  assign pc_inc        = inc_c & reset;
  assign pc_load       = load_c & reset;
  assign pc_load_value = reset ? load_val_c : '0;
  assign state_dbg     = state;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer with a reg_pc model, an
// instruction memory responder and an expected-instruction queue.
module tb_pc_fetch_sequencer;
  import pc_fetch_pkg::*;

  localparam logic [15:0] START = 16'h0000;
  localparam int          TO_CYCLES = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  logic        start = 1'b0;
  logic [15:0] pc_value;
  logic        pc_inc, pc_load;
  logic [15:0] pc_load_value;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready = 1'b0;
  logic        branch_take = 1'b0;
  logic [15:0] branch_target = '0;
  logic        halt = 1'b0;
  logic        halted, fetch_err;
  fetch_state_e state_dbg;

  pc_fetch_sequencer #(
    .START_ADDR    (START),
    .INSTR_W       (16),
    .TIMEOUT_CYCLES(TO_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .pc_value     (pc_value),
    .pc_inc       (pc_inc),
    .pc_load      (pc_load),
    .pc_load_value(pc_load_value),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .instr        (instr),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .branch_take  (branch_take),
    .branch_target(branch_target),
    .halt         (halt),
    .halted       (halted),
    .fetch_err    (fetch_err),
    .state_dbg    (state_dbg)
  );

  // reg_pc model
  logic [15:0] pc_model = '0;
  always @(posedge clk) begin
    if (pc_load)     pc_model <= pc_load_value;
    else if (pc_inc) pc_model <= pc_model + 16'd1;
  end
  assign pc_value = pc_model;

  // ---------------- scoreboard state ----------------
  logic [15:0] exp_q[$];
  logic [15:0] exp_fetch_addr = START;
  int          n_tests = 0;
  int          n_fail  = 0;
  int          ack_delay = 0;
  int          wait_cnt  = 0;
  bit          ready_rand = 1'b0;
  bit          ready_en   = 1'b1;
  int          n_inc = 0, n_issued = 0;
  logic        s_pc_inc, s_pc_load;
  logic [15:0] s_pc_load_value;

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- driver: one clock cycle ----------------
  // Called just after a rising edge; drives memory/decode inputs, samples
  // and checks mid-cycle, then returns just after the next rising edge.
  task automatic run_cycle();
    if (imem_req && wait_cnt >= ack_delay) begin
      imem_ack   = 1'b1;
      imem_rdata = mem_word(imem_addr);
      wait_cnt   = 0;
    end else begin
      imem_ack   = 1'b0;
      imem_rdata = '0;
      if (imem_req) wait_cnt++;
      else          wait_cnt = 0;
    end
    instr_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_en;
    #2;
    s_pc_inc        = pc_inc;
    s_pc_load       = pc_load;
    s_pc_load_value = pc_load_value;
    check_eq("inc_load_excl", 32'(pc_inc & pc_load), 0);
    if (imem_ack) begin
      check_eq("fetch_addr", imem_addr, exp_fetch_addr);
      check_eq("pc_inc_on_ack", pc_inc, 1);
      if (!halt) exp_q.push_back(mem_word(exp_fetch_addr));
      exp_fetch_addr = exp_fetch_addr + 16'd1;
    end else begin
      check_eq("pc_inc_no_ack", pc_inc, 0);
    end
    if (pc_inc) n_inc++;
    if (instr_valid) begin
      check_eq("no_req_in_issue", imem_req, 0);
      check_eq("exp_q_nonempty", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        check_eq("instr", instr, exp_q[0]);
        if (halt) begin
          void'(exp_q.pop_front());
        end else if (instr_ready) begin
          void'(exp_q.pop_front());
          n_issued++;
          if (branch_take) begin
            check_eq("branch_load", pc_load, 1);
            check_eq("branch_value", pc_load_value, branch_target);
            exp_fetch_addr = branch_target;
          end
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int inc0, iss0, req_cycles;

    // Reset state, with start already high: Mealy load must stay low.
    start = 1'b1;
    #3;
    check_eq("rst_req", imem_req, 0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_pc_load", pc_load, 0);
    check_eq("rst_pc_inc", pc_inc, 0);
    check_eq("rst_load_val", pc_load_value, 0);
    check_eq("rst_fetch_err", fetch_err, 0);
    check_eq("rst_state", state_dbg, ST_IDLE);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Linear run, 1-cycle memory, ready tied high.
    exp_fetch_addr = START;
    ready_en = 1'b1;
    ack_delay = 0;
    run_cycle();
    check_eq("start_load", s_pc_load, 1);
    check_eq("start_load_val", s_pc_load_value, START);
    start = 1'b0;
    check_eq("start_req", imem_req, 1);
    check_eq("start_addr", imem_addr, START);
    inc0 = n_inc;
    iss0 = n_issued;
    for (int i = 0; i < 6; i++) begin
      run_cycle();
      check_eq("lin_valid_pattern", instr_valid, 32'((i % 2) == 0));
    end
    check_eq("lin_issued", n_issued - iss0, 3);
    check_eq("lin_inc_pulses", n_inc - inc0, 3);
    check_eq("lin_pc", pc_model, START + 16'd3);

    // Back-pressure: decode stalls for 5 cycles.
    ready_en = 1'b0;
    run_cycle();
    for (int i = 0; i < 5; i++) begin
      run_cycle();
      check_eq("bp_valid_held", instr_valid, 1);
      check_eq("bp_no_req", imem_req, 0);
      check_eq("bp_instr_stable", instr, mem_word(START + 16'd3));
    end
    ready_en = 1'b1;
    run_cycle();
    check_eq("bp_valid_drop", instr_valid, 0);
    check_eq("bp_next_req", imem_req, 1);
    check_eq("bp_next_addr", imem_addr, START + 16'd4);

    // Taken branch on acceptance.
    run_cycle();
    branch_take   = 1'b1;
    branch_target = 16'h0040;
    run_cycle();
    check_eq("br_pc_load", s_pc_load, 1);
    check_eq("br_load_val", s_pc_load_value, 16'h0040);
    check_eq("br_no_inc", s_pc_inc, 0);
    branch_take = 1'b0;
    check_eq("br_next_addr", imem_addr, 16'h0040);
    check_eq("br_pc_model", pc_model, 16'h0040);

    // Halt during FETCH with ack delayed 3 cycles.
    ack_delay = 3;
    halt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      run_cycle();
      check_eq("halt_req_held", imem_req, 1);
      check_eq("halt_addr_held", imem_addr, 16'h0040);
    end
    run_cycle();
    check_eq("halt_halted", halted, 1);
    check_eq("halt_no_valid", instr_valid, 0);
    check_eq("halt_req_drop", imem_req, 0);
    check_eq("halt_state", state_dbg, ST_HALTED);
    check_eq("halt_discard", exp_q.size(), 0);
    start = 1'b1;
    run_cycle();
    check_eq("halt_prio_load", s_pc_load, 0);
    check_eq("halt_prio_halted", halted, 1);

    // Restart from HALTED.
    halt = 1'b0;
    ack_delay = 0;
    exp_fetch_addr = START;
    run_cycle();
    start = 1'b0;
    check_eq("restart_load", s_pc_load, 1);
    check_eq("restart_val", s_pc_load_value, START);
    check_eq("restart_halted", halted, 0);
    check_eq("restart_addr", imem_addr, START);
    iss0 = n_issued;
    run_cycle();
    run_cycle();
    check_eq("restart_issued", n_issued - iss0, 1);

    // Halt in ISSUE wins over a same-cycle ready.
    ready_en = 1'b0;
    run_cycle();
    halt = 1'b1;
    ready_en = 1'b1;
    iss0 = n_issued;
    run_cycle();
    check_eq("issue_halt_valid", instr_valid, 0);
    check_eq("issue_halt_halted", halted, 1);
    check_eq("issue_halt_no_accept", n_issued - iss0, 0);
    halt = 1'b0;

    // Random delays and back-pressure.
    start = 1'b1;
    exp_fetch_addr = START;
    run_cycle();
    start = 1'b0;
    ready_rand = 1'b1;
    for (int i = 0; i < 60; i++) begin
      ack_delay = $urandom_range(0, 3);
      run_cycle();
    end
    ready_rand = 1'b0;
    ready_en = 1'b1;

    // Reset in the middle of an outstanding fetch.
    ack_delay = 20;
    for (int i = 0; i < 12 && !imem_req; i++) run_cycle();
    check_eq("reach_fetch", imem_req, 1);
    run_cycle();
    #2;
    reset = 1'b0;
    #1;
    check_eq("midrst_req", imem_req, 0);
    check_eq("midrst_valid", instr_valid, 0);
    check_eq("midrst_halted", halted, 0);
    check_eq("midrst_state", state_dbg, ST_IDLE);
    exp_q.delete();
    wait_cnt = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;

`ifdef PC_FETCH_TIMEOUT_EN
    // Fetch timeout: memory never acks.
    ack_delay = 100000;
    start = 1'b1;
    exp_fetch_addr = START;
    run_cycle();
    start = 1'b0;
    req_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req) req_cycles++;
      run_cycle();
    end
    check_eq("to_req_cycles", req_cycles, TO_CYCLES);
    check_eq("to_req_drop", imem_req, 0);
    check_eq("to_fetch_err", fetch_err, 1);
    check_eq("to_halted", halted, 1);
    check_eq("to_no_inc", pc_model, START);
    start = 1'b1;
    run_cycle();
    start = 1'b0;
    check_eq("to_err_sticky", fetch_err, 1);
    check_eq("to_restart_req", imem_req, 1);
    #2;
    reset = 1'b0;
    #1;
    check_eq("to_err_cleared", fetch_err, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
`else
    req_cycles = 0;
    check_eq("fetch_err_tied", fetch_err, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Bound on total run time.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, tests=%0d failed=%0d", n_tests, n_fail);
    $fatal(1);
  end

endmodule
